// File: rtl/percept_node.sv
// Addressable perceptron node: deserialises a shared one-bit line, decodes 3-byte
// packets for this address, and runs a sequential signed MAC with threshold.
module percept_node #(
  parameter int N       = 4,
  parameter int TIMEOUT = 32
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic               serial_in,
  input  logic [7:0]         address,
  output logic signed [17:0] acc,
  output logic               y,
  output logic               done,
  output logic               busy
);

  // state   | meaning
  // RX_IDLE | waiting for a low start bit
  // RX_BITS | shifting in 8 data bits, LSB first
  // RX_WAIT | byte complete, waiting for the line to return high
  typedef enum logic [1:0] {RX_IDLE, RX_BITS, RX_WAIT} rx_state_t;

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  rx_state_t         rx_q, rx_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              byte_vld_q, byte_vld_d;
  logic [1:0]        pkt_cnt_q, pkt_cnt_d;
  logic              hit_q, hit_d;
  logic [1:0]        op_q, op_d;
  logic [5:0]        idx_q, idx_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic signed [7:0] w_q [N];
  logic signed [7:0] w_d [N];
  logic signed [7:0] x_q [N];
  logic signed [7:0] x_d [N];
  logic              busy_q, busy_d;
  logic [IW-1:0]     mac_idx_q, mac_idx_d;
  logic signed [17:0] acc_int_q, acc_int_d;
  logic signed [17:0] acc_q, acc_d;
  logic              y_q, y_d;
  logic              done_q, done_d;

  logic              exec;
  logic              tmo_run;
  logic signed [15:0] prod;
  logic signed [17:0] sum;

  always_comb begin
    rx_d       = rx_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_vld_d = 1'b0;
    case (rx_q)
      RX_IDLE: begin
        if (!serial_in) begin
          rx_d      = RX_BITS;
          bit_cnt_d = 3'd0;
        end
      end
      RX_BITS: begin
        shift_d   = {serial_in, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          rx_d       = RX_WAIT;
          byte_vld_d = 1'b1;
        end
      end
      RX_WAIT: begin
        // a held-low line stays here, so it can never look like a start bit
        if (serial_in) rx_d = RX_IDLE;
      end
      default: rx_d = RX_IDLE;
    endcase
  end

  // Packet framing: timeout is a down-counter that runs only while a packet
  // is partially received and the receiver sits idle.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    hit_d     = hit_q;
    op_d      = op_q;
    idx_d     = idx_q;
    exec      = 1'b0;
    tmo_run   = (rx_q == RX_IDLE) && (pkt_cnt_q != 2'd0);
    tmo_d     = TW'(TIMEOUT);
    if (tmo_run) tmo_d = tmo_q - 1'b1;
    if (byte_vld_q) begin
      case (pkt_cnt_q)
        2'd0: begin
          hit_d     = (shift_q == address);
          pkt_cnt_d = 2'd1;
        end
        2'd1: begin
          op_d      = shift_q[7:6];
          idx_d     = shift_q[5:0];
          pkt_cnt_d = 2'd2;
        end
        default: begin
          exec      = hit_q && !busy_q;
          pkt_cnt_d = 2'd0;
        end
      endcase
    end else if (tmo_run && (tmo_q == TW'(1))) begin
      pkt_cnt_d = 2'd0;
      tmo_d     = TW'(TIMEOUT);
    end
  end

  always_comb begin
    w_d       = w_q;
    x_d       = x_q;
    busy_d    = busy_q;
    mac_idx_d = mac_idx_q;
    acc_int_d = acc_int_q;
    acc_d     = acc_q;
    y_d       = y_q;
    done_d    = 1'b0;
    prod      = 16'(w_q[mac_idx_q]) * 16'(x_q[mac_idx_q]);
    sum       = acc_int_q + 18'(prod);
    if (exec) begin
      case (op_q)
        2'b00: for (int i = 0; i < N; i++) if (idx_q == 6'(i)) w_d[i] = shift_q;
        2'b01: for (int i = 0; i < N; i++) if (idx_q == 6'(i)) x_d[i] = shift_q;
        2'b10: begin
          busy_d    = 1'b1;
          mac_idx_d = '0;
          acc_int_d = {{10{shift_q[7]}}, shift_q};
        end
        default: begin
          for (int i = 0; i < N; i++) begin
            w_d[i] = '0;
            x_d[i] = '0;
          end
        end
      endcase
    end
    if (busy_q) begin
      acc_int_d = sum;
      mac_idx_d = mac_idx_q + 1'b1;
      if (mac_idx_q == IW'(N - 1)) begin
        busy_d = 1'b0;
        acc_d  = sum;
        y_d    = !sum[17] && (sum != '0);
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      rx_q       <= RX_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      byte_vld_q <= 1'b0;
      pkt_cnt_q  <= '0;
      hit_q      <= 1'b0;
      op_q       <= '0;
      idx_q      <= '0;
      tmo_q      <= TW'(TIMEOUT);
      for (int i = 0; i < N; i++) begin
        w_q[i] <= '0;
        x_q[i] <= '0;
      end
      busy_q     <= 1'b0;
      mac_idx_q  <= '0;
      acc_int_q  <= '0;
      acc_q      <= '0;
      y_q        <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rx_q       <= rx_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_vld_q <= byte_vld_d;
      pkt_cnt_q  <= pkt_cnt_d;
      hit_q      <= hit_d;
      op_q       <= op_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      w_q        <= w_d;
      x_q        <= x_d;
      busy_q     <= busy_d;
      mac_idx_q  <= mac_idx_d;
      acc_int_q  <= acc_int_d;
      acc_q      <= acc_d;
      y_q        <= y_d;
      done_q     <= done_d;
    end
  end

  assign acc  = acc_q;
  assign y    = y_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_percept_node.sv
// Bench for percept_node: directed packet table, framing/reset sequences, and
// random packets checked against an arithmetic model of the node.
module tb_percept_node;
  localparam int N       = 4;
  localparam int TIMEOUT = 32;
  localparam logic [7:0] NODE = 8'h01;

  logic               clk;
  logic               nRst;
  logic               serial_in;
  logic [7:0]         address;
  logic signed [17:0] acc;
  logic               y;
  logic               done;
  logic               busy;

  percept_node #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .nRst(nRst), .serial_in(serial_in), .address(address),
    .acc(acc), .y(y), .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  int m_w [N];
  int m_x [N];
  int m_acc = 0;
  int m_y   = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [1:0]  op;
    logic [5:0]  idx;
    logic [7:0]  data;
    bit          has_exp;
    int          exp_acc;
    int          exp_y;
  } vec_t;

  vec_t tbl [20];

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: evaluation is bias plus the dot product, wrapped to 18 bits.
  function automatic void model_apply(input logic [7:0] a, input logic [1:0] op,
                                      input logic [5:0] idx, input logic [7:0] d);
    int s;
    logic [17:0] r;
    if (a != NODE) return;
    case (op)
      2'b00: if (int'(idx) < N) m_w[idx] = int'($signed(d));
      2'b01: if (int'(idx) < N) m_x[idx] = int'($signed(d));
      2'b10: begin
        s = int'($signed(d));
        for (int i = 0; i < N; i++) s += m_w[i] * m_x[i];
        r = s[17:0];
        m_acc = int'($signed(r));
        m_y = (m_acc > 0) ? 1 : 0;
      end
      default: for (int i = 0; i < N; i++) begin m_w[i] = 0; m_x[i] = 0; end
    endcase
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk) serial_in = 1'b0;
    for (int k = 0; k < 8; k++) @(negedge clk) serial_in = b[k];
    @(negedge clk) serial_in = 1'b1;
  endtask

  // Called right after the last byte's stop bit is driven.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 3 * N + 10; c++) begin
      @(posedge clk); #1;
      if (c == 1) check("busy_rise", int'(busy), 1);
      if (done) begin
        lat = c;
        break;
      end
    end
    check("latency", lat, N + 1);
    check("busy_fall", int'(busy), 0);
    @(posedge clk); #1;
    check("done_width", int'(done), 0);
  endtask

  task automatic finish_packet(input logic [7:0] a, input logic [1:0] op,
                               input bit has_exp, input int exp_acc, input int exp_y);
    int lat;
    int seen;
    if (a == NODE && op == 2'b10) begin
      wait_done(lat);
      check("acc", int'(acc), m_acc);
      check("y", int'(y), m_y);
      if (has_exp) begin
        check("acc_tbl", int'(acc), exp_acc);
        check("y_tbl", int'(y), exp_y);
      end
    end else begin
      seen = 0;
      for (int c = 0; c < N + 3; c++) begin
        @(posedge clk); #1;
        if (done || busy) seen = 1;
      end
      check("no_done", seen, 0);
      check("acc_hold", int'(acc), m_acc);
    end
  endtask

  task automatic do_packet(input logic [7:0] a, input logic [1:0] op, input logic [5:0] idx,
                           input logic [7:0] d, input bit has_exp, input int exp_acc,
                           input int exp_y);
    send_byte(a);
    send_byte({op, idx});
    send_byte(d);
    model_apply(a, op, idx, d);
    finish_packet(a, op, has_exp, exp_acc, exp_y);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] b0;
    for (int i = 0; i < N; i++) begin m_w[i] = 0; m_x[i] = 0; end
    tbl[0]  = '{8'h01, 2'b00, 6'd0, 8'h02, 1'b0, 0, 0};
    tbl[1]  = '{8'h01, 2'b00, 6'd1, 8'hFD, 1'b0, 0, 0};
    tbl[2]  = '{8'h01, 2'b01, 6'd0, 8'h05, 1'b0, 0, 0};
    tbl[3]  = '{8'h01, 2'b01, 6'd1, 8'h01, 1'b0, 0, 0};
    tbl[4]  = '{8'h01, 2'b10, 6'd0, 8'h00, 1'b1, 7, 1};
    tbl[5]  = '{8'h01, 2'b10, 6'd0, 8'hF8, 1'b1, -1, 0};
    tbl[6]  = '{8'h02, 2'b00, 6'd0, 8'h7F, 1'b0, 0, 0};
    tbl[7]  = '{8'h01, 2'b10, 6'd0, 8'hF8, 1'b1, -1, 0};
    for (int i = 0; i < 4; i++) begin
      tbl[8 + 2*i] = '{8'h01, 2'b00, 6'(i), 8'h80, 1'b0, 0, 0};
      tbl[9 + 2*i] = '{8'h01, 2'b01, 6'(i), 8'h80, 1'b0, 0, 0};
    end
    tbl[16] = '{8'h01, 2'b10, 6'd0, 8'h7F, 1'b1, 65663, 1};
    tbl[17] = '{8'h01, 2'b11, 6'd0, 8'h00, 1'b0, 0, 0};
    tbl[18] = '{8'h01, 2'b10, 6'd0, 8'h00, 1'b1, 0, 0};
    tbl[19] = '{8'h01, 2'b00, 6'd5, 8'h33, 1'b0, 0, 0};

    nRst = 1'b0;
    serial_in = 1'b1;
    address = NODE;
    repeat (3) @(posedge clk);
    #1;
    check("rst_acc", int'(acc), 0);
    check("rst_y", int'(y), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    @(negedge clk) nRst = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 20; v++)
      do_packet(tbl[v].addr, tbl[v].op, tbl[v].idx, tbl[v].data,
                tbl[v].has_exp, tbl[v].exp_acc, tbl[v].exp_y);

    // byte0 ending in a low bit, then the line held low well past the byte
    b0 = NODE;
    @(negedge clk) serial_in = 1'b0;
    for (int k = 0; k < 8; k++) @(negedge clk) serial_in = b0[k];
    @(negedge clk) serial_in = 1'b0;
    repeat (12) @(negedge clk);
    serial_in = 1'b1;
    send_byte({2'b10, 6'd0});
    send_byte(8'h05);
    model_apply(NODE, 2'b10, 6'd0, 8'h05);
    finish_packet(NODE, 2'b10, 1'b1, 5, 1);

    // lone byte0 followed by a long idle must be abandoned
    send_byte(NODE);
    repeat (TIMEOUT + 8) @(negedge clk);
    do_packet(NODE, 2'b10, 6'd0, 8'h03, 1'b1, 3, 1);

    // reset in the middle of an evaluation
    do_packet(NODE, 2'b00, 6'd0, 8'h03, 1'b0, 0, 0);
    do_packet(NODE, 2'b01, 6'd0, 8'h03, 1'b1, 0, 0);
    do_packet(NODE, 2'b10, 6'd0, 8'h00, 1'b1, 9, 1);
    send_byte(NODE);
    send_byte({2'b10, 6'd0});
    send_byte(8'h01);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_busy", int'(busy), 1);
    nRst = 1'b0;
    #1;
    check("mac_rst_busy", int'(busy), 0);
    check("mac_rst_done", int'(done), 0);
    check("mac_rst_acc", int'(acc), 0);
    check("mac_rst_y", int'(y), 0);
    for (int i = 0; i < N; i++) begin m_w[i] = 0; m_x[i] = 0; end
    m_acc = 0;
    m_y = 0;
    repeat (N + 3) begin
      @(posedge clk); #1;
      if (done) check("aborted_done", int'(done), 0);
    end
    @(negedge clk) nRst = 1'b1;
    @(negedge clk);
    do_packet(NODE, 2'b10, 6'd0, 8'h00, 1'b1, 0, 0);

    for (int r = 0; r < 80; r++) begin
      ra = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(2, 255)) : NODE;
      do_packet(ra, 2'($urandom_range(0, 3)), 6'($urandom_range(0, N + 1)),
                8'($urandom), 1'b0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
